// File: rtl/seg_display_mux.sv
// Four-digit common-anode seven-segment scanner: latches converter digit codes and
// sign, then time-multiplexes units, tens, hundreds and a sign digit with optional zero blanking.
module seg_display_mux #(
    parameter int         CLK_DIV   = 50000,
    parameter bit         BLANK_LZ  = 1'b1,
    parameter logic [6:0] ZERO_SEG  = 7'h40,
    parameter logic [6:0] MINUS_SEG = 7'h3F,
    parameter logic [6:0] BLANK_SEG = 7'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] U,
    input  logic [6:0] T,
    input  logic [6:0] H,
    input  logic       sign,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [6:0]       u_r;
    logic [6:0]       t_r;
    logic [6:0]       h_r;
    logic             s_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;

    logic             tc_s;
    logic [DIV_W-1:0] div_nxt_s;
    logic [1:0]       idx_nxt_s;
    logic [6:0]       seg_nxt_s;
    logic [3:0]       an_nxt_s;
    logic             frame_nxt_s;

    // Tens blank only when hundreds is also zero, so "105" keeps its inner zero.
    function automatic logic [6:0] digit_code(
        input logic [1:0] idx,
        input logic [6:0] u,
        input logic [6:0] t,
        input logic [6:0] h,
        input logic       s
    );
        logic [6:0] code;
        case (idx)
            2'd0: code = u;
            2'd1: begin
                if (BLANK_LZ && (h == ZERO_SEG) && (t == ZERO_SEG)) begin
                    code = BLANK_SEG;
                end else begin
                    code = t;
                end
            end
            2'd2: begin
                if (BLANK_LZ && (h == ZERO_SEG)) begin
                    code = BLANK_SEG;
                end else begin
                    code = h;
                end
            end
            2'd3: begin
                if (s) begin
                    code = MINUS_SEG;
                end else begin
                    code = BLANK_SEG;
                end
            end
            default: code = BLANK_SEG;
        endcase
        return code;
    endfunction

    // Next prescaler/index state and next display outputs; disabled scan holds its position.
    always_comb begin
        tc_s        = (div_cnt_r == DIV_LAST);
        div_nxt_s   = div_cnt_r;
        idx_nxt_s   = idx_r;
        seg_nxt_s   = BLANK_SEG;
        an_nxt_s    = 4'hF;
        frame_nxt_s = 1'b0;
        if (enable) begin
            if (tc_s) begin
                div_nxt_s = {DIV_W{1'b0}};
                idx_nxt_s = idx_r + 2'd1;
            end else begin
                div_nxt_s = div_cnt_r + DIV_W'(1);
                idx_nxt_s = idx_r;
            end
            seg_nxt_s   = digit_code(idx_r, u_r, t_r, h_r, s_r);
            an_nxt_s    = ~(4'b0001 << idx_r);
            frame_nxt_s = tc_s && (idx_r == 2'd3);
        end else begin
            div_nxt_s   = div_cnt_r;
            idx_nxt_s   = idx_r;
            seg_nxt_s   = BLANK_SEG;
            an_nxt_s    = 4'hF;
            frame_nxt_s = 1'b0;
        end
    end

    // Shadow capture, scan state and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            u_r       <= ZERO_SEG;
            t_r       <= ZERO_SEG;
            h_r       <= ZERO_SEG;
            s_r       <= 1'b0;
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= 2'd0;
            seg       <= BLANK_SEG;
            an        <= 4'hF;
            frame     <= 1'b0;
        end else begin
            if (load) begin
                u_r <= U;
                t_r <= T;
                h_r <= H;
                s_r <= sign;
            end
            div_cnt_r <= div_nxt_s;
            idx_r     <= idx_nxt_s;
            seg       <= seg_nxt_s;
            an        <= an_nxt_s;
            frame     <= frame_nxt_s;
        end
    end

endmodule
